// File: rtl/rotate_amount_finder.sv
// rotate_amount_finder
//   Multi-cycle inverse of the barrel_shifter rotate. It finds the smallest amount that
//   rotates the original word onto the rotated word in the chosen direction. The search
//   advances by one 1-bit rotate step per cycle.
//
// Parameters
//   WIDTH  data word width
//   AMT_W  amount width (2**AMT_W must exceed WIDTH)
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   request, sampled only while busy=0
//   in_reg  original (unrotated) word
//   in_rot  rotated word to decode
//   in_m    direction searched: 1 = right rotate, 0 = left rotate
//   busy    high while searching
//   done    one-cycle pulse when the result is valid
//   found   1 = a matching amount exists in 0..WIDTH-1
//   o_amt   decoded amount (0 when found=0)

module rotate_amount_finder #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AMT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in_reg,
   input  logic [WIDTH-1:0] in_rot,
   input  logic             in_m,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [AMT_W-1:0] o_amt
);

   typedef enum logic {StIdle, StSearch} state_t;

   localparam logic [AMT_W-1:0] LastCnt = AMT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] tgt;
   logic             dir;
   logic [AMT_W-1:0] cnt;
   logic [WIDTH-1:0] work_step;

   // One-bit rotate of the work register in the captured direction.
   always_comb begin
      work_step = work;
      if (dir) begin
         work_step = {work[0], work[WIDTH-1:1]};
      end else begin
         work_step = {work[WIDTH-2:0], work[WIDTH-1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= StIdle;
         work  <= '0;
         tgt   <= '0;
         dir   <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         found <= 1'b0;
         o_amt <= '0;
      end else begin
         // done is a single-cycle pulse unless re-raised below.
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  work  <= in_reg;
                  tgt   <= in_rot;
                  dir   <= in_m;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  found <= 1'b0;
                  o_amt <= '0;
                  state <= StSearch;
               end
            end
            StSearch: begin
               // The compare is checked before the limit so an amount of WIDTH-1 still matches.
               if (work == tgt) begin
                  found <= 1'b1;
                  o_amt <= cnt;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= StIdle;
               end else if (cnt == LastCnt) begin
                  found <= 1'b0;
                  o_amt <= '0;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= StIdle;
               end else begin
                  work <= work_step;
                  cnt  <= cnt + 1'b1;
               end
            end
            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rotate_amount_finder.sv
module tb_rotate_amount_finder;

   localparam int WIDTH = 32;
   localparam int AMT_W = 6;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] in_reg;
   logic [WIDTH-1:0] in_rot;
   logic             in_m;
   logic             busy;
   logic             done;
   logic             found;
   logic [AMT_W-1:0] o_amt;

   rotate_amount_finder #(
      .WIDTH(WIDTH),
      .AMT_W(AMT_W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .in_reg(in_reg),
      .in_rot(in_rot),
      .in_m  (in_m),
      .busy  (busy),
      .done  (done),
      .found (found),
      .o_amt (o_amt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             found;
      logic [AMT_W-1:0] amt;
      int               cyc;      // negedge index at which done must be seen
      int               busy_len; // busy-high negedges before done
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   busy_run = 0;

   // Scoreboard monitor: compares every done pulse against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (done) begin
         if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending op", cyc);
         end else begin
            e = sb.pop_front();
            checks++;
            if (found !== e.found) begin
               errors++;
               $display("FAIL sb_found: got %b, required %b", found, e.found);
            end
            checks++;
            if (o_amt !== e.amt) begin
               errors++;
               $display("FAIL sb_amt: got %0d, required %0d", o_amt, e.amt);
            end
            checks++;
            if (cyc !== e.cyc) begin
               errors++;
               $display("FAIL sb_latency: done at cycle %0d, required %0d", cyc, e.cyc);
            end
            checks++;
            if (busy_run !== e.busy_len) begin
               errors++;
               $display("FAIL sb_busy_len: got %0d, required %0d", busy_run, e.busy_len);
            end
         end
         busy_run = 0;
      end else if (busy) begin
         busy_run++;
      end else begin
         busy_run = 0;
      end
   end

   // Called just after a negedge; the next posedge samples start (E0).
   task automatic issue(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] t, input logic m,
                        input logic exp_found, input int exp_amt);
      exp_t e;
      int   lat;
      lat        = exp_found ? exp_amt + 1 : WIDTH;
      e.found    = exp_found;
      e.amt      = AMT_W'(exp_amt);
      e.cyc      = cyc + 1 + lat;
      e.busy_len = lat;
      sb.push_back(e);
      in_reg = r;
      in_rot = t;
      in_m   = m;
      start  = 1'b1;
      @(negedge clk);
      #1;
      start  = 1'b0;
      in_reg = $urandom;
      in_rot = $urandom;
      in_m   = 1'($urandom);
   endtask

   // Returns just after the negedge where done is seen.
   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (done !== 1'b1) begin
         errors++;
         checks++;
         $display("FAIL %s_timeout: done not seen within %0d cycles, required done=1", name, n);
      end
      #1;
   endtask

   function automatic logic [WIDTH-1:0] rot_ref(input logic [WIDTH-1:0] x, input int s,
                                                input logic right);
      logic [2*WIDTH-1:0] d;
      d = {x, x};
      if (right) begin
         d = d >> s;
         return d[WIDTH-1:0];
      end
      d = d << s;
      return d[2*WIDTH-1:WIDTH];
   endfunction

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      in_reg = '0;
      in_rot = '0;
      in_m  = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, found, o_amt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b found=%b amt=%0d, required all 0",
                  busy, done, found, o_amt);
      end
      rst = 1'b0;
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset_mid_search();
      issue(32'h00000001, 32'h00000003, 1'b0, 1'b0, 0);
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, found, o_amt} !== '0) begin
         errors++;
         $display("FAIL reset_mid_search: got busy=%b done=%b found=%b amt=%0d, required all 0",
                  busy, done, found, o_amt);
      end
      sb.delete();
      @(negedge clk);
      #1;
      rst = 1'b0;
      repeat (40) @(negedge clk);
      #1;
      // Any done pulse from the aborted search would be flagged by the monitor.
      issue(32'hD36093AD, 32'hE9B049D6, 1'b1, 1'b1, 1);
      wait_done("after_reset");
   endtask

   task automatic test_start_while_busy();
      issue(32'hD36093AD, 32'hDD36093A, 1'b1, 1'b1, 4);
      @(negedge clk);
      #1;
      in_reg = 32'h12345678;
      in_rot = 32'h12345678;
      in_m   = 1'b0;
      start  = 1'b1;
      @(negedge clk);
      #1;
      start = 1'b0;
      wait_done("busy_start");
      repeat (3) @(negedge clk);
      checks++;
      if (found !== 1'b1 || o_amt !== 6'd4 || busy !== 1'b0) begin
         errors++;
         $display("FAIL hold_result: got found=%b amt=%0d busy=%b, required found=1 amt=4 busy=0",
                  found, o_amt, busy);
      end
      #1;
   endtask

   task automatic test_right_decode();
      issue(32'hD36093AD, 32'hE9B049D6, 1'b1, 1'b1, 1);
      wait_done("right1");
      issue(32'hD36093AD, 32'hDD36093A, 1'b1, 1'b1, 4);
      wait_done("right4");
   endtask

   task automatic test_left_periodic_identity();
      issue(32'hD36093AD, 32'h6093ADD3, 1'b0, 1'b1, 8);
      wait_done("left8");
      issue(32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 1'b1, 0);
      wait_done("identity");
      issue(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b1, 1);
      wait_done("periodic_left");
      issue(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b1, 1);
      wait_done("periodic_right");
      issue(32'h00000000, 32'h00000000, 1'b1, 1'b1, 0);
      wait_done("zeros");
   endtask

   task automatic test_no_match();
      issue(32'h00000001, 32'h00000003, 1'b1, 1'b0, 0);
      wait_done("no_match");
      checks++;
      if (found !== 1'b0 || o_amt !== '0) begin
         errors++;
         $display("FAIL no_match_hold: got found=%b amt=%0d, required found=0 amt=0",
                  found, o_amt);
      end
   endtask

   // Each start is raised in the done cycle of the previous op; exact latency in the
   // scoreboard proves there is no gap cycle.
   task automatic test_back_to_back();
      logic [WIDTH-1:0] base;
      base = 32'hD36093AD;
      for (int d = 0; d < 2; d++) begin
         for (int s = 0; s < WIDTH; s++) begin
            issue(base, rot_ref(base, s, 1'(d)), 1'(d), 1'b1, s);
            wait_done("round_trip");
         end
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_right_decode();
      test_left_periodic_identity();
      test_no_match();
      test_start_while_busy();
      test_reset_mid_search();
      test_back_to_back();
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
